increment_repeat_controller: RTL and testbench

//   Turns the raw "increment" push-button into clean one-cycle increment strobes for the time-set path.
//   - Synchronises and debounces the button.
//   - Emits one strobe per press, then auto-repeats while the button is held.
//   - Strobes are emitted only while the mode FSM grants increments (SET_MIN / SET_HOUR); the mode FSM

---
 rtl/increment_repeat_controller.sv | 161 ++++++++++++++++
 tb/tb_increment_repeat_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/increment_repeat_controller.sv
// Increment push-button conditioner: synchronise, debounce, then emit one strobe per press
// followed by auto-repeat strobes while held and while the mode FSM grants increments.
module increment_repeat_controller #(
  parameter int DEBOUNCE_CYCLES      = 50000,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Button,
  input  logic i_Enable_Increment,
  output logic o_Increment,
  output logic o_Button_Level,
  output logic o_Repeating
);

  localparam int DbW      = $clog2(DEBOUNCE_CYCLES);
  localparam int ArmW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TimerMax = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                            REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int TmrW     = $clog2(TimerMax);

  localparam logic [DbW-1:0]  DbLast     = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ArmW-1:0] ArmLast    = ArmW'(DEBOUNCE_CYCLES);
  localparam logic [TmrW-1:0] DelayLast  = TmrW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TmrW-1:0] PeriodLast = TmrW'(REPEAT_PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_e;

  logic            syncMeta_q;
  logic            syncOut_q;
  logic [DbW-1:0]  dbCnt_q;
  logic            level_q;
  logic            levelPrev_q;
  logic [ArmW-1:0] armCnt_q;
  logic            blocked_q;
  state_e          state_q;
  state_e          state_d;
  logic [TmrW-1:0] timer_q;
  logic [TmrW-1:0] timer_d;
  logic            incr_q;
  logic            incr_d;
  logic            repeating_q;

  logic rise;
  logic startPress;
  logic holdOk;

  assign rise       = level_q & ~levelPrev_q;
  assign startPress = rise & i_Enable_Increment & ~blocked_q;
  assign holdOk     = level_q & i_Enable_Increment;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      syncMeta_q  <= 1'b0;
      syncOut_q   <= 1'b0;
      dbCnt_q     <= '0;
      level_q     <= 1'b0;
      levelPrev_q <= 1'b0;
    end else begin
      syncMeta_q  <= i_Button;
      syncOut_q   <= syncMeta_q;
      levelPrev_q <= level_q;
      if (syncOut_q == level_q) begin
        dbCnt_q <= '0;
      end else if (dbCnt_q == DbLast) begin
        level_q <= syncOut_q;
        dbCnt_q <= '0;
      end else begin
        dbCnt_q <= dbCnt_q + DbW'(1);
      end
    end
  end

  // A press held through reset must not strobe: stay blocked until the button has been
  // seen released (synchronised and debounced low) for longer than the debounce window.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      armCnt_q  <= '0;
      blocked_q <= 1'b1;
    end else if (blocked_q) begin
      if (!syncOut_q && !level_q) begin
        if (armCnt_q == ArmLast) begin
          blocked_q <= 1'b0;
          armCnt_q  <= '0;
        end else begin
          armCnt_q <= armCnt_q + ArmW'(1);
        end
      end else begin
        armCnt_q <= '0;
      end
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      incr_q      <= 1'b0;
      repeating_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      incr_q      <= incr_d;
      repeating_q <= (state_d == REPEAT);
    end
  end

  // Release or loss of grant always returns to IDLE, even on a terminal count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (startPress) state_d = DELAY;
      end
      DELAY: begin
        if (!holdOk) state_d = IDLE;
        else if (timer_q == DelayLast) state_d = REPEAT;
      end
      REPEAT: begin
        if (!holdOk) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    incr_d  = 1'b0;
    timer_d = '0;
    case (state_q)
      IDLE: begin
        incr_d = startPress;
      end
      DELAY: begin
        if (holdOk) begin
          if (timer_q == DelayLast) incr_d = 1'b1;
          else timer_d = timer_q + TmrW'(1);
        end
      end
      REPEAT: begin
        if (holdOk) begin
          if (timer_q == PeriodLast) incr_d = 1'b1;
          else timer_d = timer_q + TmrW'(1);
        end
      end
      default: begin
        incr_d  = 1'b0;
        timer_d = '0;
      end
    endcase
  end

  assign o_Increment    = incr_q;
  assign o_Button_Level = level_q;
  assign o_Repeating    = repeating_q;

endmodule

// File: tb/tb_increment_repeat_controller.sv
// Bench for the increment button conditioner: directed scenarios plus randomized button
// activity, all compared against a press-session model built from elapsed-cycle arithmetic.
module tb_increment_repeat_controller;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic clock = 1'b0;
   logic reset;
   logic button;
   logic enable;
   logic incr;
   logic level;
   logic repeating;

   int checks   = 0;
   int failures = 0;

   // Reference model state: synchroniser as a two-deep delay line, debounced level,
   // and a press session tracked by cycles elapsed since its first strobe.
   bit mS1, mS2, mLevel, mLevelPrev, mArmed, mActive, mIncr, mRep;
   int mDiff, mZero, mK;

   increment_repeat_controller #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY_CYCLES(RD),
      .REPEAT_PERIOD_CYCLES(RP)
   ) dut (
      .i_Clock(clock),
      .i_Reset(reset),
      .i_Button(button),
      .i_Enable_Increment(enable),
      .o_Increment(incr),
      .o_Button_Level(level),
      .o_Repeating(repeating)
   );

   always #5 clock = ~clock;

   task automatic modelReset();
      mS1 = 0; mS2 = 0; mLevel = 0; mLevelPrev = 0; mArmed = 0;
      mActive = 0; mIncr = 0; mRep = 0; mDiff = 0; mZero = 0; mK = 0;
   endtask

   task automatic modelStep(input bit b, input bit e);
      bit s, lvl, rose, armed, strobe;
      s      = mS2;
      lvl    = mLevel;
      rose   = mLevel && !mLevelPrev;
      armed  = mArmed;
      strobe = 0;
      if (mActive) begin
         if (!e || !lvl) mActive = 0;
         else begin
            mK++;
            if (mK == RD || (mK > RD && (mK - RD) % RP == 0)) strobe = 1;
         end
      end else if (rose && e && armed) begin
         mActive = 1;
         mK      = 0;
         strobe  = 1;
      end
      mRep = mActive && (mK >= RD);
      mLevelPrev = lvl;
      if (s != lvl) begin
         mDiff++;
         if (mDiff == D) begin
            mLevel = s;
            mDiff  = 0;
         end
      end else mDiff = 0;
      if (!armed) begin
         if (!s && !lvl) begin
            mZero++;
            if (mZero == D + 1) mArmed = 1;
         end else mZero = 0;
      end
      mS2   = mS1;
      mS1   = b;
      mIncr = strobe;
   endtask

   task automatic tick();
      @(posedge clock);
      modelStep(button, enable);
      #1;
   endtask

   task automatic applyStimulus(input bit b, input bit e);
      @(negedge clock);
      button = b;
      enable = e;
      tick();
   endtask

   task automatic test_reset();
      reset = 1; button = 0; enable = 0;
      modelReset();
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({incr, repeating, level} !== 3'b000) begin
         failures++;
         $display("FAIL reset_outputs got=%b%b%b exp=000", incr, repeating, level);
      end
      @(negedge clock);
      reset = 0;
      for (int t = 1; t <= 12; t++) begin
         applyStimulus(0, 1);
         checks++;
         if ({incr, repeating, level} !== {mIncr, mRep, mLevel}) begin
            failures++;
            $display("FAIL reset_idle t=%0d got=%b%b%b exp=%b%b%b", t, incr, repeating, level, mIncr, mRep, mLevel);
         end
      end
   endtask

   task automatic test_single_press();
      int count = 0;
      int at = -1;
      for (int t = 1; t <= 24; t++) begin
         applyStimulus(t <= 8, 1);
         if (incr) begin count++; at = t; end
         checks++;
         if ({incr, repeating, level} !== {mIncr, mRep, mLevel}) begin
            failures++;
            $display("FAIL single_press t=%0d got=%b%b%b exp=%b%b%b", t, incr, repeating, level, mIncr, mRep, mLevel);
         end
      end
      checks++;
      if (count !== 1 || at !== 7) begin
         failures++;
         $display("FAIL single_press_timing strobes=%0d at=%0d exp strobes=1 at=7", count, at);
      end
   endtask

   task automatic test_hold_repeat();
      bit expInc, expRep;
      for (int t = 1; t <= 55; t++) begin
         applyStimulus(t <= 40, 1);
         expInc = (t == 7) || (t >= 17 && t <= 46 && (t - 17) % 3 == 0);
         expRep = (t >= 17 && t <= 46);
         checks++;
         if (incr !== expInc || repeating !== expRep) begin
            failures++;
            $display("FAIL hold_repeat t=%0d got incr=%b rep=%b exp incr=%b rep=%b", t, incr, repeating, expInc, expRep);
         end
         checks++;
         if ({incr, repeating, level} !== {mIncr, mRep, mLevel}) begin
            failures++;
            $display("FAIL hold_repeat_model t=%0d got=%b%b%b exp=%b%b%b", t, incr, repeating, level, mIncr, mRep, mLevel);
         end
      end
   endtask

   task automatic test_bounce();
      bit pattern [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
      for (int t = 1; t <= 20; t++) begin
         applyStimulus((t <= 8) ? pattern[t - 1] : 1'b0, 1);
         checks++;
         if (level !== 1'b0 || incr !== 1'b0) begin
            failures++;
            $display("FAIL bounce t=%0d got level=%b incr=%b exp level=0 incr=0", t, level, incr);
         end
      end
   endtask

   task automatic test_enable_gating();
      int gated = 0;
      int live = 0;
      for (int t = 1; t <= 75; t++) begin
         if (t <= 30) applyStimulus(1, 0);
         else if (t <= 40) applyStimulus(1, 1);
         else if (t <= 55) applyStimulus(0, 1);
         else if (t <= 65) applyStimulus(1, 1);
         else applyStimulus(0, 1);
         if (incr) begin
            if (t <= 55) gated++;
            else live++;
         end
         checks++;
         if ({incr, repeating, level} !== {mIncr, mRep, mLevel}) begin
            failures++;
            $display("FAIL enable_gating t=%0d got=%b%b%b exp=%b%b%b", t, incr, repeating, level, mIncr, mRep, mLevel);
         end
      end
      checks++;
      if (gated !== 0 || live !== 1) begin
         failures++;
         $display("FAIL enable_gating_count gated=%0d repress=%0d exp gated=0 repress=1", gated, live);
      end
   endtask

   task automatic test_enable_drop();
      for (int t = 1; t <= 45; t++) begin
         if (t <= 30) applyStimulus(1, !(t >= 23));
         else applyStimulus(0, 1);
         if (t == 20 || t == 22 || t == 23) begin
            checks++;
            if ((t == 20 && incr !== 1'b1) || (t == 22 && repeating !== 1'b1) ||
                (t == 23 && (incr !== 1'b0 || repeating !== 1'b0))) begin
               failures++;
               $display("FAIL enable_drop t=%0d got incr=%b rep=%b", t, incr, repeating);
            end
         end
         checks++;
         if ({incr, repeating, level} !== {mIncr, mRep, mLevel}) begin
            failures++;
            $display("FAIL enable_drop_model t=%0d got=%b%b%b exp=%b%b%b", t, incr, repeating, level, mIncr, mRep, mLevel);
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      int held = 0;
      int fresh = 0;
      for (int t = 1; t <= 21; t++) applyStimulus(1, 1);
      checks++;
      if (repeating !== 1'b1) begin
         failures++;
         $display("FAIL reset_hold_prep got rep=%b exp rep=1", repeating);
      end
      #2;
      reset = 1;
      modelReset();
      #1;
      checks++;
      if ({incr, repeating, level} !== 3'b000) begin
         failures++;
         $display("FAIL reset_async got=%b%b%b exp=000", incr, repeating, level);
      end
      @(negedge clock);
      @(negedge clock);
      reset = 0;
      tick();
      for (int t = 1; t <= 80; t++) begin
         if (t <= 40) applyStimulus(1, 1);
         else if (t <= 55) applyStimulus(0, 1);
         else if (t <= 65) applyStimulus(1, 1);
         else applyStimulus(0, 1);
         if (incr) begin
            if (t <= 55) held++;
            else fresh++;
         end
         checks++;
         if ({incr, repeating, level} !== {mIncr, mRep, mLevel}) begin
            failures++;
            $display("FAIL reset_hold_model t=%0d got=%b%b%b exp=%b%b%b", t, incr, repeating, level, mIncr, mRep, mLevel);
         end
      end
      checks++;
      if (held !== 0 || fresh !== 1) begin
         failures++;
         $display("FAIL reset_hold_count held=%0d repress=%0d exp held=0 repress=1", held, fresh);
      end
   endtask

   task automatic test_random();
      bit b = 0;
      bit e = 1;
      bit prevIncr = 0;
      int runLeft = 0;
      for (int t = 1; t <= 2000; t++) begin
         if (runLeft == 0) begin
            b = ~b;
            runLeft = (b ? $urandom_range(1, 40) : $urandom_range(1, 20));
         end
         runLeft--;
         if ($urandom_range(0, 39) == 0) e = ~e;
         applyStimulus(b, e);
         checks++;
         if ({incr, repeating, level} !== {mIncr, mRep, mLevel}) begin
            failures++;
            $display("FAIL random t=%0d got=%b%b%b exp=%b%b%b", t, incr, repeating, level, mIncr, mRep, mLevel);
         end
         checks++;
         if (prevIncr && incr) begin
            failures++;
            $display("FAIL random_double_strobe t=%0d got consecutive strobes exp isolated", t);
         end
         prevIncr = incr;
      end
   endtask

   initial begin
      $display("[TB] starting increment_repeat_controller bench");
      test_reset();
      test_single_press();
      test_hold_repeat();
      test_bounce();
      test_enable_gating();
      test_enable_drop();
      test_reset_mid_hold();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
